// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module : program_loader_pkg
// Brief  : Shared loader state encoding, frame marker and default geometry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package program_loader_pkg;

    localparam int         C_INSTR_BYTES = 2;
    localparam int         C_ADDR_WIDTH  = 5;
    localparam logic [7:0] C_SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/loader_word_assembler.sv
// ============================================================================
// Module : loader_word_assembler
// Brief  : MSB-first byte shift register with a word-complete strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int INSTR_BYTES = C_INSTR_BYTES
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     byte_en,
    input  logic [7:0]               byte_in,
    output logic [8*INSTR_BYTES-1:0] word_next,
    output logic                     word_done
);

    localparam int INSTR_W = 8 * INSTR_BYTES;
    localparam int CNT_W   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    logic [INSTR_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_count;

    // The completed word is presented combinationally so the caller can
    // register it on the same edge that takes the last byte.
    assign word_next = (r_shift << 8) | INSTR_W'(byte_in);
    assign word_done = byte_en && (r_count == CNT_W'(INSTR_BYTES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (byte_en) begin
            r_shift <= word_next;
            r_count <= word_done ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Framed byte stream to instruction RAM writer with XOR checksum.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int         INSTR_BYTES = C_INSTR_BYTES,
    parameter int         ADDR_WIDTH  = C_ADDR_WIDTH,
    parameter logic [7:0] SYNC_BYTE   = C_SYNC_BYTE
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [8*INSTR_BYTES-1:0] mem_wdata,
    output logic                     load_done,
    output logic                     load_err
);

    localparam int INSTR_W = 8 * INSTR_BYTES;

    loader_state_t          r_state;
    loader_state_t          w_next;
    logic [ADDR_WIDTH-1:0]  r_index;
    logic [ADDR_WIDTH-1:0]  r_n_last;
    logic [7:0]             r_csum;
    logic                   w_take;
    logic                   w_asm_en;
    logic                   w_len_bad;
    logic                   w_last_word;
    logic                   w_ready_next;
    logic                   w_word_done;
    logic [INSTR_W-1:0]     w_word_next;

    assign w_take      = rx_valid && rx_ready;
    assign w_asm_en    = w_take && (r_state == S_DATA);
    assign w_len_bad   = (rx_data >> ADDR_WIDTH) != 8'd0;
    assign w_last_word = (r_index == r_n_last);

    loader_word_assembler #(
        .INSTR_BYTES (INSTR_BYTES)
    ) u_asm (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (r_state == S_LEN),
        .byte_en   (w_asm_en),
        .byte_in   (rx_data),
        .word_next (w_word_next),
        .word_done (w_word_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take && rx_data == SYNC_BYTE) w_next = S_LEN;
            S_LEN:   if (w_take) w_next = w_len_bad ? S_ERR : S_DATA;
            S_DATA:  if (w_word_done && w_last_word) w_next = S_CHK;
            S_CHK:   if (w_take) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
            default: w_next = r_state;
        endcase
        w_ready_next = (w_next != S_DONE) && (w_next != S_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Status flags follow the state one edge later, so a verdict on CHK
    // becomes visible on the edge after it is taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            r_index   <= '0;
            r_n_last  <= '0;
            r_csum    <= '0;
        end else begin
            mem_we    <= 1'b0;
            rx_ready  <= w_ready_next;
            load_done <= (r_state == S_DONE);
            load_err  <= (r_state == S_ERR);
            if (w_take && r_state == S_LEN) begin
                r_n_last <= rx_data[ADDR_WIDTH-1:0];
                r_csum   <= rx_data;
                r_index  <= '0;
            end
            if (w_asm_en) begin
                r_csum <= r_csum ^ rx_data;
            end
            if (w_word_done) begin
                mem_we    <= 1'b1;
                mem_addr  <= r_index;
                mem_wdata <= w_word_next;
                r_index   <= r_index + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire
